// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, buffers returned
// instructions with their PCs in a small FIFO and hands them to decode; redirects flush.
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] wptr_q, wptr_d;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];

   logic [CW:0]   committed_cnt;
   logic [31:0]   redirect_addr;
   logic          req_fire;
   logic          rsp_take;
   logic          rsp_drop;
   logic          push;
   logic          pop;

   // Masking (rather than slicing) keeps every redirect_pc bit in use.
   assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;

   // Entries already buffered plus kept requests still outstanding; capping this at DEPTH
   // guarantees room in the FIFO for every response that will be kept.
   assign committed_cnt = {1'b0, occ_q} + {1'b0, inflight_q} - {1'b0, drop_q};

   assign imem_req_valid = rst_n && !redirect_valid && (committed_cnt < DEPTH_W);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing in flight is a protocol violation and is ignored.
   assign rsp_take = imem_rsp_valid && (inflight_q != '0);
   assign rsp_drop = rsp_take && (drop_q != '0);
   assign push     = rsp_take && (drop_q == '0);

   assign out_valid = (occ_q != '0);
   assign out_inst  = inst_mem_q[rptr_q[AW-1:0]];
   assign out_pc    = pc_mem_q[rptr_q[AW-1:0]];
   assign pop       = out_valid && out_ready;

   always_comb begin
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
      drop_d     = drop_q - CW'(rsp_drop);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;

      if (req_fire) begin
         pc_d = pc_q + 32'd4;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push) begin
         wptr_d   = wptr_q + 1'b1;
         rsp_pc_d = rsp_pc_q + 32'd4;
      end

      // Redirect wins: the queue empties and every response still owed is discarded.
      // No request fires in a redirect cycle, so inflight_d is already post-retirement.
      if (redirect_valid) begin
         pc_d     = redirect_addr;
         rsp_pc_d = redirect_addr;
         occ_d    = '0;
         rptr_d   = '0;
         wptr_d   = '0;
         drop_d   = inflight_d;
      end else if (push) begin
         inst_mem_d[wptr_q[AW-1:0]] = imem_rsp_data;
         pc_mem_d[wptr_q[AW-1:0]]   = rsp_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         occ_q      <= '0;
         rptr_q     <= '0;
         wptr_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         occ_q      <= occ_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
      end
   end

   rsp_without_request: assert property (
      @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (inflight_q != '0))
      else $error("imem response received with no request in flight");

endmodule
